counter_cycle_arbiter: RTL and testbench
========================================

# counter_cycle_arbiter

Steals RAM cycles from the Core pipeline to perform AGC-style involuntary counter increments (PINC/MINC) on a bank of timer/counter cells in erasable memory. Sits between Core and the erasable RAM: in idle it passes Core's RAM ports through unchanged. While servicing a counter it owns the RAM ports and raises a stall that is ORed into Core's `stall`. It also chains overflows from one counter into the next and reports overflow pulses to the interrupt logic.

## Interface
- `NUM_CTR`, default 4: number of counter cells.
- `CTR_BASE`, default 11'o24: RAM address of counter 0; counter i lives at `CTR_BASE + i`.
- `CHAIN_MASK`, default 4'b0001: bit i set means an overflow of counter i raises a PINC request on counter i+1. Bit `NUM_CTR-1` is ignored.

Ports (clock and reset first):
- `clock`  in  1  sole clock; everything is updated on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctr_req`  in  NUM_CTR  one-cycle request pulse per counter.
- `ctr_minus`  in  NUM_CTR  direction, sampled with `ctr_req`: 1 = MINC, 0 = PINC.
- `core_RAM_read_address`  in  11  Core read address.
- `core_RAM_write_address`  in  11  Core write address.
- `core_RAM_write_data`  in  15  Core write data.
- `core_RAM_write_en`  in  1  Core write enable.
- `RAM_read_data`  in  15  RAM read data; synchronous, valid the cycle after the address.
- `RAM_read_address`  out  11  muxed read address to RAM.
- `RAM_write_address`  out  11  muxed write address to RAM.
- `RAM_write_data`  out  15  muxed write data to RAM.
- `RAM_write_en`  out  1  muxed write enable to RAM.
- `core_stall`  out  1  stall request to Core.
- `ovf_pulse`  out  NUM_CTR  one-cycle overflow indication per counter (registered).
- `req_dropped`  out  1  one-cycle pulse (registered): a request hit an already-pending counter.
- `pending`  out  NUM_CTR  pending request bits.

## Operation
- **Request capture:** on a `ctr_req[i]` pulse, set `pending[i]` and latch `dir[i] = ctr_minus[i]`.
  - If `pending[i]` is already set and is not being cleared that edge, drop the request and pulse `req_dropped`.
  - If a request coincides with the clearing of the same counter, the new request wins: the bit stays set and its direction is re-latched.
- **Selection:** fixed priority, lowest index first. `sel` is registered on entry to READ.
- **States:** IDLE, READ, MODIFY, WRITE.
  - IDLE: RAM ports equal the core_* inputs. `core_stall=0`. If any pending bit is set, go to READ.
  - READ: `RAM_read_address = CTR_BASE+sel`. Core write signals still pass through. `core_stall=1`. Go to MODIFY.
  - MODIFY: capture `RAM_read_data` and compute the result into a 15-bit register along with an overflow flag. `core_stall=1`. Go to WRITE.
  - WRITE: if `core_RAM_write_en=1`, the Core write passes and the FSM stays in WRITE. Otherwise drive `RAM_write_*` with the counter address and result, clear `pending[sel]`, and go to READ if any other bit is still pending, else to IDLE. `core_stall=1`.
- **Collision abort:** in MODIFY or WRITE, a Core write whose address equals `CTR_BASE+sel` is passed through, and the FSM returns to READ to re-read the cell.
- **Arithmetic (15-bit ones' complement):**
  - PINC:
    - 37777 -> 00000 with overflow.
    - 77777 -> 00001.
    - otherwise +1.
  - MINC:
    - 40000 -> 77777 with overflow.
    - 00000 -> 77776.
    - otherwise -1.
- **Overflow handling:** at the write-commit edge, pulse `ovf_pulse[sel]`. If `CHAIN_MASK[sel]` is set, also set `pending[sel+1]` with PINC direction. If that bit is already pending, the chained request is dropped and `req_dropped` pulses.

## Timing
- Reset values:
  - state IDLE, `pending=0`, `sel=0`.
  - `core_stall=0`, `ovf_pulse=0`, `req_dropped=0`.
  - RAM outputs equal the core_* passthrough.
- Service latency:
  - A request sampled at edge N gives `pending` high after N.
  - READ spans cycle N+1, MODIFY N+2, WRITE N+3.
  - The write commits at edge N+4 when uncontested.
- `core_stall` is combinational from state: high in READ, MODIFY and WRITE.
- Back-to-back service costs 3 cycles per counter, and `core_stall` stays high continuously between them.
- Reset asserted mid-sequence: returns immediately to IDLE, no write is issued, and all pending requests are lost.

## Test plan
- PINC on counter 2 holding 00005: `ctr_req=4'b0100` -> RAM[CTR_BASE+2]=00006 at edge N+4, `core_stall` high for exactly 3 cycles, no `ovf_pulse`.
- Counter 0 at 37777, PINC -> writes 00000, `ovf_pulse[0]` pulses, counter 1 then services a PINC (10 -> 11) with `core_stall` held for 6 contiguous cycles.
- MINC cases: 40000 -> 77777 with `ovf_pulse`; 00000 -> 77776; PINC on 77777 -> 00001.
- `ctr_req=4'b1010` in the same cycle -> counter 1 is serviced before counter 3. A repeat `ctr_req[3]` while it is pending -> `req_dropped` pulse, and only one increment happens.
- Core write enabled during WRITE to an unrelated address -> Core write lands first and the counter write lands one cycle later.
- Core write to the counter address during MODIFY -> FSM re-reads, and the final value is the Core value ±1.
- `reset_n` low during MODIFY -> no RAM write, `pending=0`, `core_stall=0` immediately.

Source files
------------

// File: rtl/counter_cycle_arbiter.sv
// Steals RAM cycles from Core to apply ones'-complement PINC/MINC to a bank of counter cells.
// Idle passes Core RAM ports through; servicing runs READ -> MODIFY -> WRITE with Core stalled.
module counter_cycle_arbiter #(
  parameter int unsigned         NUM_CTR    = 4,
  parameter logic [10:0]         CTR_BASE   = 11'o24,
  parameter logic [NUM_CTR-1:0]  CHAIN_MASK = 'b0001
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_CTR-1:0] ctr_req,
  input  logic [NUM_CTR-1:0] ctr_minus,
  input  logic [10:0]        core_RAM_read_address,
  input  logic [10:0]        core_RAM_write_address,
  input  logic [14:0]        core_RAM_write_data,
  input  logic               core_RAM_write_en,
  input  logic [14:0]        RAM_read_data,
  output logic [10:0]        RAM_read_address,
  output logic [10:0]        RAM_write_address,
  output logic [14:0]        RAM_write_data,
  output logic               RAM_write_en,
  output logic               core_stall,
  output logic [NUM_CTR-1:0] ovf_pulse,
  output logic               req_dropped,
  output logic [NUM_CTR-1:0] pending
);

  localparam int unsigned SEL_W = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_MODIFY, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic [NUM_CTR-1:0] pending_q, pending_d;
  logic [NUM_CTR-1:0] dir_q, dir_d;
  logic [NUM_CTR-1:0] ovf_pulse_q, ovf_pulse_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [14:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               req_dropped_q, req_dropped_d;

  logic [10:0]        ctr_addr;
  logic [NUM_CTR-1:0] sel_onehot;
  logic [NUM_CTR-1:0] clr_vec;
  logic [NUM_CTR-1:0] chain_vec;
  logic               commit;
  logic               collide;
  logic [14:0]        inc_val;
  logic               inc_ovf;

  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_CTR-1:0] v);
    first_set = '0;
    for (int i = NUM_CTR - 1; i >= 0; i--) begin
      if (v[i]) first_set = SEL_W'(i);
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTR; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_q == SEL_W'(gi));
    end
  endgenerate

  assign ctr_addr  = CTR_BASE + 11'(sel_q);
  assign collide   = core_RAM_write_en && (core_RAM_write_address == ctr_addr);
  // A WRITE-state cycle commits only when Core is not using the write port.
  assign commit    = (state_q == S_WRITE) && !core_RAM_write_en;
  assign clr_vec   = commit ? sel_onehot : '0;
  // Overflow of the top counter shifts out, so its mask bit has no effect.
  assign chain_vec = (commit && ovf_q) ? ((sel_onehot & CHAIN_MASK) << 1) : '0;

  always_comb begin
    inc_val = RAM_read_data;
    inc_ovf = 1'b0;
    if (dir_q[sel_q]) begin
      if (RAM_read_data == 15'o40000) begin
        inc_val = 15'o77777;
        inc_ovf = 1'b1;
      end else if (RAM_read_data == 15'o00000) begin
        inc_val = 15'o77776;
      end else begin
        inc_val = RAM_read_data - 15'd1;
      end
    end else begin
      if (RAM_read_data == 15'o37777) begin
        inc_val = 15'o00000;
        inc_ovf = 1'b1;
      end else if (RAM_read_data == 15'o77777) begin
        inc_val = 15'o00001;
      end else begin
        inc_val = RAM_read_data + 15'd1;
      end
    end
  end

  always_comb begin
    pending_d     = pending_q & ~clr_vec;
    dir_d         = dir_q;
    ovf_pulse_d   = (commit && ovf_q) ? sel_onehot : '0;
    req_dropped_d = 1'b0;
    for (int i = 0; i < NUM_CTR; i++) begin
      // A request landing on the edge its counter is cleared re-arms it.
      if (ctr_req[i]) begin
        if (pending_q[i] && !clr_vec[i]) begin
          req_dropped_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          dir_d[i]     = ctr_minus[i];
        end
      end
      if (chain_vec[i]) begin
        if (pending_q[i] || ctr_req[i]) begin
          req_dropped_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          dir_d[i]     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    sel_d             = sel_q;
    result_d          = result_q;
    ovf_d             = ovf_q;
    RAM_read_address  = core_RAM_read_address;
    RAM_write_address = core_RAM_write_address;
    RAM_write_data    = core_RAM_write_data;
    RAM_write_en      = core_RAM_write_en;
    core_stall        = 1'b1;
    case (state_q)
      S_IDLE: begin
        core_stall = 1'b0;
        if (|pending_q) state_d = S_READ;
      end
      S_READ: begin
        RAM_read_address = ctr_addr;
        state_d          = S_MODIFY;
      end
      S_MODIFY: begin
        result_d = inc_val;
        ovf_d    = inc_ovf;
        state_d  = collide ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        if (collide) begin
          state_d = S_READ;
        end else if (commit) begin
          RAM_write_address = ctr_addr;
          RAM_write_data    = result_q;
          RAM_write_en      = 1'b1;
          state_d           = (|pending_d) ? S_READ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_READ) sel_d = first_set(pending_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      dir_q         <= '0;
      sel_q         <= '0;
      result_q      <= '0;
      ovf_q         <= 1'b0;
      ovf_pulse_q   <= '0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      dir_q         <= dir_d;
      sel_q         <= sel_d;
      result_q      <= result_d;
      ovf_q         <= ovf_d;
      ovf_pulse_q   <= ovf_pulse_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  assign pending     = pending_q;
  assign ovf_pulse   = ovf_pulse_q;
  assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_counter_cycle_arbiter.sv
// Directed bench for counter_cycle_arbiter: RAM model, write scoreboard, stall/overflow/drop checks.
module tb_counter_cycle_arbiter;

  localparam logic [10:0] BASE = 11'o24;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  ctr_req = '0;
  logic [3:0]  ctr_minus = '0;
  logic [10:0] core_RAM_read_address = '0;
  logic [10:0] core_RAM_write_address = '0;
  logic [14:0] core_RAM_write_data = '0;
  logic        core_RAM_write_en = 1'b0;
  logic [14:0] RAM_read_data;
  logic [10:0] RAM_read_address;
  logic [10:0] RAM_write_address;
  logic [14:0] RAM_write_data;
  logic        RAM_write_en;
  logic        core_stall;
  logic [3:0]  ovf_pulse;
  logic        req_dropped;
  logic [3:0]  pending;

  logic [14:0] mem [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [14:0] pre_data = '0;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q [$];

  typedef struct {
    int          idx;
    bit          minus;
    logic [14:0] init;
    logic [14:0] res;
    bit          ovf;
  } vec_t;
  vec_t vecs [7];

  always #5 clock = ~clock;

  counter_cycle_arbiter #(
    .NUM_CTR(4), .CTR_BASE(BASE), .CHAIN_MASK(4'b0001)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .ctr_req(ctr_req), .ctr_minus(ctr_minus),
    .core_RAM_read_address(core_RAM_read_address),
    .core_RAM_write_address(core_RAM_write_address),
    .core_RAM_write_data(core_RAM_write_data),
    .core_RAM_write_en(core_RAM_write_en),
    .RAM_read_data(RAM_read_data),
    .RAM_read_address(RAM_read_address),
    .RAM_write_address(RAM_write_address),
    .RAM_write_data(RAM_write_data),
    .RAM_write_en(RAM_write_en),
    .core_stall(core_stall),
    .ovf_pulse(ovf_pulse),
    .req_dropped(req_dropped),
    .pending(pending)
  );

  // Synchronous RAM; the bench preload port borrows a cycle while the DUT is idle.
  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (RAM_write_en) mem[RAM_write_address] <= RAM_write_data;
    RAM_read_data <= mem[RAM_read_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (RAM_write_en) begin
      logic [25:0] e;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(RAM_write_address), 32'(e[25:15]));
        chk("wr_data", 32'(RAM_write_data), 32'(e[14:0]));
        $display("write addr=%0o data=%0o", RAM_write_address, RAM_write_data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [14:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic run(input logic [3:0] req, input logic [3:0] minus,
                     input int inj_cyc, input logic [3:0] inj_req,
                     input int cw_cyc, input logic [10:0] cw_addr, input logic [14:0] cw_data,
                     output int stall_n, output logic [3:0] ovf_acc, output logic drop_acc);
    bit seen;
    bit done;
    seen = 0; done = 0;
    stall_n = 0; ovf_acc = '0; drop_acc = 1'b0;
    ctr_req = req; ctr_minus = minus;
    tick();
    ctr_req = '0; ctr_minus = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == inj_cyc) ctr_req = inj_req;
      if (c == cw_cyc) begin
        core_RAM_write_en = 1'b1; core_RAM_write_address = cw_addr; core_RAM_write_data = cw_data;
      end
      tick();
      ctr_req = '0; core_RAM_write_en = 1'b0;
      ovf_acc  = ovf_acc | ovf_pulse;
      drop_acc = drop_acc | req_dropped;
      if (core_stall) begin
        stall_n++; seen = 1;
      end else if (seen) begin
        done = 1;
      end
    end
    chk("run_terminated", 32'(done), 32'd1);
  endtask

  initial begin
    int sn;
    logic [3:0] ov;
    logic dr;

    // Reset state and passthrough.
    core_RAM_read_address = 11'o1234; core_RAM_write_address = 11'o777; core_RAM_write_data = 15'o12345;
    tick(); tick();
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(ovf_pulse), 32'd0);
    chk("rst_drop", 32'(req_dropped), 32'd0);
    chk("rst_rd_addr", 32'(RAM_read_address), 32'(11'o1234));
    chk("rst_wr_addr", 32'(RAM_write_address), 32'(11'o777));
    chk("rst_wr_data", 32'(RAM_write_data), 32'(15'o12345));
    chk("rst_wr_en", 32'(RAM_write_en), 32'd0);
    reset_n = 1'b1;
    tick();

    // Idle Core write passes through.
    exp_q.push_back({11'o200, 15'o4321});
    core_RAM_write_en = 1'b1; core_RAM_write_address = 11'o200; core_RAM_write_data = 15'o4321;
    tick();
    core_RAM_write_en = 1'b0;
    chk("idle_write_mem", 32'(mem[11'o200]), 32'(15'o4321));

    // PINC on counter 2: 5 -> 6, three stall cycles, no overflow.
    preload(BASE + 11'd2, 15'o5);
    exp_q.push_back({BASE + 11'd2, 15'o6});
    run(4'b0100, 4'b0000, -1, '0, -1, '0, '0, sn, ov, dr);
    $display("pinc ctr2 stall=%0d ovf=%b", sn, ov);
    chk("pinc_stall", 32'(sn), 32'd3);
    chk("pinc_ovf", 32'(ov), 32'd0);
    chk("pinc_mem", 32'(mem[BASE + 11'd2]), 32'(15'o6));
    chk("pinc_pending", 32'(pending), 32'd0);

    // Overflow on counter 0 chains into counter 1.
    preload(BASE, 15'o37777);
    preload(BASE + 11'd1, 15'o10);
    exp_q.push_back({BASE, 15'o0});
    exp_q.push_back({BASE + 11'd1, 15'o11});
    run(4'b0001, 4'b0000, -1, '0, -1, '0, '0, sn, ov, dr);
    $display("chain stall=%0d ovf=%b", sn, ov);
    chk("chain_stall", 32'(sn), 32'd6);
    chk("chain_ovf", 32'(ov), 32'b0001);
    chk("chain_mem1", 32'(mem[BASE + 11'd1]), 32'(15'o11));
    chk("chain_pending", 32'(pending), 32'd0);

    // Ones'-complement arithmetic boundary cases.
    vecs[0] = '{2, 1'b1, 15'o40000, 15'o77777, 1'b1};
    vecs[1] = '{3, 1'b1, 15'o00000, 15'o77776, 1'b0};
    vecs[2] = '{3, 1'b0, 15'o77777, 15'o00001, 1'b0};
    vecs[3] = '{1, 1'b1, 15'o00005, 15'o00004, 1'b0};
    vecs[4] = '{1, 1'b0, 15'o37776, 15'o37777, 1'b0};
    vecs[5] = '{2, 1'b0, 15'o37777, 15'o00000, 1'b1};
    vecs[6] = '{3, 1'b1, 15'o77777, 15'o77776, 1'b0};
    for (int k = 0; k < 7; k++) begin
      logic [3:0] m;
      m = 4'(1) << vecs[k].idx;
      preload(BASE + 11'(vecs[k].idx), vecs[k].init);
      exp_q.push_back({BASE + 11'(vecs[k].idx), vecs[k].res});
      run(m, vecs[k].minus ? m : 4'b0000, -1, '0, -1, '0, '0, sn, ov, dr);
      $display("arith %0d ctr=%0d minus=%0d %0o -> %0o ovf=%b", k, vecs[k].idx, vecs[k].minus,
               vecs[k].init, mem[BASE + 11'(vecs[k].idx)], ov);
      chk($sformatf("arith%0d_stall", k), 32'(sn), 32'd3);
      chk($sformatf("arith%0d_ovf", k), 32'(ov), vecs[k].ovf ? 32'(m) : 32'd0);
      chk($sformatf("arith%0d_mem", k), 32'(mem[BASE + 11'(vecs[k].idx)]), 32'(vecs[k].res));
    end

    // Priority (1 before 3) and a dropped repeat on pending counter 3.
    preload(BASE + 11'd1, 15'o100);
    preload(BASE + 11'd3, 15'o200);
    exp_q.push_back({BASE + 11'd1, 15'o101});
    exp_q.push_back({BASE + 11'd3, 15'o201});
    run(4'b1010, 4'b0000, 1, 4'b1000, -1, '0, '0, sn, ov, dr);
    $display("prio stall=%0d drop=%0d", sn, dr);
    chk("prio_stall", 32'(sn), 32'd6);
    chk("prio_drop", 32'(dr), 32'd1);
    chk("prio_mem3", 32'(mem[BASE + 11'd3]), 32'(15'o201));
    chk("prio_pending", 32'(pending), 32'd0);

    // Unrelated Core write during WRITE lands first; counter write follows.
    preload(BASE + 11'd2, 15'o7);
    exp_q.push_back({11'o300, 15'o1111});
    exp_q.push_back({BASE + 11'd2, 15'o10});
    run(4'b0100, 4'b0000, -1, '0, 3, 11'o300, 15'o1111, sn, ov, dr);
    $display("defer stall=%0d", sn);
    chk("defer_stall", 32'(sn), 32'd4);
    chk("defer_core_mem", 32'(mem[11'o300]), 32'(15'o1111));
    chk("defer_ctr_mem", 32'(mem[BASE + 11'd2]), 32'(15'o10));

    // Core write to the counter cell during MODIFY forces a re-read.
    preload(BASE + 11'd2, 15'o50);
    exp_q.push_back({BASE + 11'd2, 15'o1000});
    exp_q.push_back({BASE + 11'd2, 15'o1001});
    run(4'b0100, 4'b0000, -1, '0, 2, BASE + 11'd2, 15'o1000, sn, ov, dr);
    $display("abort stall=%0d", sn);
    chk("abort_stall", 32'(sn), 32'd5);
    chk("abort_mem", 32'(mem[BASE + 11'd2]), 32'(15'o1001));

    // Reset asserted during MODIFY: no write, everything cleared at once.
    preload(BASE + 11'd2, 15'o123);
    ctr_req = 4'b0100;
    tick();
    ctr_req = '0;
    tick(); tick();
    chk("mid_stall_before", 32'(core_stall), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(core_stall), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_wr_en", 32'(RAM_write_en), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    $display("reset mid-service mem=%0o", mem[BASE + 11'd2]);
    chk("mid_rst_after_stall", 32'(core_stall), 32'd0);
    chk("mid_rst_after_pending", 32'(pending), 32'd0);
    chk("mid_rst_mem", 32'(mem[BASE + 11'd2]), 32'(15'o123));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
